// File: rtl/mmsa_in_deser.sv
// mmsa_in_deser: serial-to-parallel front end for the MMSA systolic-array core.
// Turns the 1-bit 'matrix' stream into tagged DATA_W-bit elements (MSB first),
// and the paired serial index bits into (i_idx, w_idx) matrix-index pairs.
// Requires DATA_W >= 3 and IDX_W >= 3 (shift registers hold all but the last bit).
module mmsa_in_deser #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 4,
  parameter int NUM_MAT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_valid2,
  input  logic              matrix,
  input  logic [1:0]        matrix_size,
  input  logic              i_mat_idx,
  input  logic              w_mat_idx,
  output logic [1:0]        size_out,
  output logic              elem_valid,
  output logic [DATA_W-1:0] elem_data,
  output logic              elem_sel,
  output logic [IDX_W-1:0]  elem_mat,
  output logic [3:0]        elem_row,
  output logic [3:0]        elem_col,
  output logic              idx_valid,
  output logic [IDX_W-1:0]  i_idx,
  output logic [IDX_W-1:0]  w_idx,
  output logic              err
);

  localparam int BW = $clog2(DATA_W);
  localparam int KW = (IDX_W > 1) ? $clog2(IDX_W) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_IDX  = 2'd2;

  localparam logic [BW-1:0]    B_LAST   = BW'(DATA_W - 1);
  localparam logic [KW-1:0]    K_LAST   = KW'(IDX_W - 1);
  localparam logic [IDX_W-1:0] MAT_LAST = IDX_W'(NUM_MAT - 1);

  // Control state
  logic [1:0]        state_q, state_d;
  logic [BW-1:0]     b_q, b_d;
  logic [DATA_W-2:0] sh_q, sh_d;
  logic [3:0]        col_q, col_d;
  logic [3:0]        row_q, row_d;
  logic [IDX_W-1:0]  mat_q, mat_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;   // full stream received
  logic              ovr_q, ovr_d;     // overrun already reported
  logic [KW-1:0]     k_q, k_d;
  logic [IDX_W-2:0]  ish_q, ish_d;
  logic [IDX_W-2:0]  wsh_q, wsh_d;

  // Registered outputs
  logic [1:0]        size_q, size_d;
  logic              elem_valid_q, elem_valid_d;
  logic [DATA_W-1:0] elem_data_q, elem_data_d;
  logic              elem_sel_q, elem_sel_d;
  logic [IDX_W-1:0]  elem_mat_q, elem_mat_d;
  logic [3:0]        elem_row_q, elem_row_d;
  logic [3:0]        elem_col_q, elem_col_d;
  logic              idx_valid_q, idx_valid_d;
  logic [IDX_W-1:0]  i_idx_q, i_idx_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic              err_q, err_d;

  logic [3:0] last_rc;    // N-1 for the latched size
  logic       load_bit;   // this cycle carries an element bit
  logic       idx_bit;    // this cycle carries an index bit pair

  // N-1 = (2 << size) - 1 written without overflowing 4 bits at N=16.
  assign last_rc = {size_q == 2'd3, size_q >= 2'd2, size_q >= 2'd1, 1'b1};

  // Next-state logic: phase FSM, element assembly, index assembly, error pulses.
  always_comb begin
    state_d      = state_q;
    b_d          = b_q;
    sh_d         = sh_q;
    col_d        = col_q;
    row_d        = row_q;
    mat_d        = mat_q;
    sel_d        = sel_q;
    done_d       = done_q;
    ovr_d        = ovr_q;
    k_d          = k_q;
    ish_d        = ish_q;
    wsh_d        = wsh_q;
    size_d       = size_q;
    elem_valid_d = 1'b0;
    elem_data_d  = elem_data_q;
    elem_sel_d   = elem_sel_q;
    elem_mat_d   = elem_mat_q;
    elem_row_d   = elem_row_q;
    elem_col_d   = elem_col_q;
    idx_valid_d  = 1'b0;
    i_idx_d      = i_idx_q;
    w_idx_d      = w_idx_q;
    err_d        = 1'b0;
    load_bit     = 1'b0;
    idx_bit      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // in_valid has priority; a simultaneous in_valid2 is flagged and dropped.
          state_d  = ST_LOAD;
          size_d   = matrix_size;
          load_bit = 1'b1;
          if (in_valid2) err_d = 1'b1;
        end else if (in_valid2) begin
          state_d = ST_IDX;
          idx_bit = 1'b1;
        end
      end
      ST_LOAD: begin
        if (in_valid2) err_d = 1'b1;
        if (!in_valid) begin
          // Leaving mid-element discards the partial element.
          if (b_q != '0) err_d = 1'b1;
          state_d = ST_IDLE;
          b_d     = '0;
          col_d   = '0;
          row_d   = '0;
          mat_d   = '0;
          sel_d   = 1'b0;
          done_d  = 1'b0;
          ovr_d   = 1'b0;
        end else begin
          load_bit = 1'b1;
        end
      end
      ST_IDX: begin
        if (in_valid) err_d = 1'b1;
        if (!in_valid2) begin
          if (k_q != '0) err_d = 1'b1;
          state_d = ST_IDLE;
          k_d     = '0;
        end else begin
          idx_bit = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_bit) begin
      if (done_q) begin
        // Bits past the final element are dropped; report only the first one.
        if (!ovr_q) begin
          err_d = 1'b1;
          ovr_d = 1'b1;
        end
      end else begin
        sh_d = {sh_q[DATA_W-3:0], matrix};
        if (b_q == B_LAST) begin
          b_d          = '0;
          elem_valid_d = 1'b1;
          elem_data_d  = {sh_q, matrix};
          elem_sel_d   = sel_q;
          elem_mat_d   = mat_q;
          elem_row_d   = row_q;
          elem_col_d   = col_q;
          // Column fastest, then row, then matrix, then set.
          if (col_q == last_rc) begin
            col_d = '0;
            if (row_q == last_rc) begin
              row_d = '0;
              if (mat_q == MAT_LAST) begin
                mat_d = '0;
                if (sel_q) begin
                  sel_d  = 1'b0;
                  done_d = 1'b1;
                end else begin
                  sel_d = 1'b1;
                end
              end else begin
                mat_d = mat_q + IDX_W'(1);
              end
            end else begin
              row_d = row_q + 4'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end else begin
          b_d = b_q + BW'(1);
        end
      end
    end

    if (idx_bit) begin
      ish_d = {ish_q[IDX_W-3:0], i_mat_idx};
      wsh_d = {wsh_q[IDX_W-3:0], w_mat_idx};
      if (k_q == K_LAST) begin
        // Pair complete; a still-high in_valid2 starts the next pair at once.
        k_d         = '0;
        idx_valid_d = 1'b1;
        i_idx_d     = {ish_q, i_mat_idx};
        w_idx_d     = {wsh_q, w_mat_idx};
      end else begin
        k_d = k_q + KW'(1);
      end
    end
  end

  // State and output registers; reset drops everything, including partial data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      b_q          <= '0;
      sh_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      mat_q        <= '0;
      sel_q        <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
      k_q          <= '0;
      ish_q        <= '0;
      wsh_q        <= '0;
      size_q       <= '0;
      elem_valid_q <= 1'b0;
      elem_data_q  <= '0;
      elem_sel_q   <= 1'b0;
      elem_mat_q   <= '0;
      elem_row_q   <= '0;
      elem_col_q   <= '0;
      idx_valid_q  <= 1'b0;
      i_idx_q      <= '0;
      w_idx_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      sh_q         <= sh_d;
      col_q        <= col_d;
      row_q        <= row_d;
      mat_q        <= mat_d;
      sel_q        <= sel_d;
      done_q       <= done_d;
      ovr_q        <= ovr_d;
      k_q          <= k_d;
      ish_q        <= ish_d;
      wsh_q        <= wsh_d;
      size_q       <= size_d;
      elem_valid_q <= elem_valid_d;
      elem_data_q  <= elem_data_d;
      elem_sel_q   <= elem_sel_d;
      elem_mat_q   <= elem_mat_d;
      elem_row_q   <= elem_row_d;
      elem_col_q   <= elem_col_d;
      idx_valid_q  <= idx_valid_d;
      i_idx_q      <= i_idx_d;
      w_idx_q      <= w_idx_d;
      err_q        <= err_d;
    end
  end

  assign size_out   = size_q;
  assign elem_valid = elem_valid_q;
  assign elem_data  = elem_data_q;
  assign elem_sel   = elem_sel_q;
  assign elem_mat   = elem_mat_q;
  assign elem_row   = elem_row_q;
  assign elem_col   = elem_col_q;
  assign idx_valid  = idx_valid_q;
  assign i_idx      = i_idx_q;
  assign w_idx      = w_idx_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mmsa_in_deser.sv
// Bench for mmsa_in_deser: directed sequence with random element data and
// random index pairs; expected tags come from element-index arithmetic.
module tb_mmsa_in_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid2, matrix, i_mat_idx, w_mat_idx;
  logic [1:0]  matrix_size;
  logic [1:0]  size_out;
  logic        elem_valid;
  logic [15:0] elem_data;
  logic        elem_sel;
  logic [3:0]  elem_mat, elem_row, elem_col;
  logic        idx_valid;
  logic [3:0]  i_idx, w_idx;
  logic        err;

  int checks = 0;
  int errors = 0;

  mmsa_in_deser dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_valid2(in_valid2),
    .matrix(matrix), .matrix_size(matrix_size), .i_mat_idx(i_mat_idx),
    .w_mat_idx(w_mat_idx), .size_out(size_out), .elem_valid(elem_valid),
    .elem_data(elem_data), .elem_sel(elem_sel), .elem_mat(elem_mat),
    .elem_row(elem_row), .elem_col(elem_col), .idx_valid(idx_valid),
    .i_idx(i_idx), .w_idx(w_idx), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, then return 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic v2, input logic m,
                       input logic [1:0] sz, input logic ib, input logic wb);
    in_valid = v; in_valid2 = v2; matrix = m; matrix_size = sz;
    i_mat_idx = ib; w_mat_idx = wb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic exp_err);
    drive(1'b0, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    chk("idle_err", err, exp_err);
    chk("idle_elem_valid", elem_valid, 1'b0);
    chk("idle_idx_valid", idx_valid, 1'b0);
  endtask

  // Stream 'count' elements starting at element index 0 and check every cycle.
  task automatic load_elems(input logic [1:0] sz, input int count,
                            input bit directed, input bit v2_first);
    int n;
    logic [15:0] val;
    logic first;
    n = 2 << sz;
    for (int e = 0; e < count; e++) begin
      val = directed ? 16'(1 << e) : 16'($urandom);
      for (int b = 0; b < 16; b++) begin
        first = (e == 0) && (b == 0);
        drive(1'b1, first & v2_first, val[15-b], first ? sz : 2'($urandom),
              1'($urandom), 1'($urandom));
        chk("load_err", err, first & v2_first);
        chk("load_idx_valid", idx_valid, 1'b0);
        if (b == 15) begin
          chk("elem_valid", elem_valid, 1'b1);
          chk("elem_data", elem_data, val);
          chk("elem_sel", elem_sel, e / (n * n * 16));
          chk("elem_mat", elem_mat, (e / (n * n)) % 16);
          chk("elem_row", elem_row, (e / n) % n);
          chk("elem_col", elem_col, e % n);
        end else begin
          chk("elem_quiet", elem_valid, 1'b0);
        end
      end
    end
    chk("size_out", size_out, sz);
  endtask

  // One index pair, continuing directly from any previous pair.
  task automatic idx_pair(input logic [3:0] iv, input logic [3:0] wv);
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 1'b1, 1'($urandom), 2'($urandom), iv[3-b], wv[3-b]);
      chk("idx_err", err, 1'b0);
      chk("idx_elem_valid", elem_valid, 1'b0);
      if (b == 3) begin
        chk("idx_valid", idx_valid, 1'b1);
        chk("i_idx", i_idx, iv);
        chk("w_idx", w_idx, wv);
      end else begin
        chk("idx_quiet", idx_valid, 1'b0);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_size"}, size_out, 0);
    chk({tag, "_elem_valid"}, elem_valid, 0);
    chk({tag, "_elem_data"}, elem_data, 0);
    chk({tag, "_elem_sel"}, elem_sel, 0);
    chk({tag, "_elem_mat"}, elem_mat, 0);
    chk({tag, "_elem_row"}, elem_row, 0);
    chk({tag, "_elem_col"}, elem_col, 0);
    chk({tag, "_idx_valid"}, idx_valid, 0);
    chk({tag, "_i_idx"}, i_idx, 0);
    chk({tag, "_w_idx"}, w_idx, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    logic [3:0] ri, rw;
    rst = 1'b1;
    in_valid = 0; in_valid2 = 0; matrix = 0; matrix_size = 0;
    i_mat_idx = 0; w_mat_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    idle_cycle(1'b0);

    // Truncated N=2 stream with one-hot element values.
    load_elems(2'd0, 8, 1'b1, 1'b0);
    idle_cycle(1'b0);

    // Partial N=16 stream: row/column tags at the largest size.
    load_elems(2'd3, 40, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Complete N=8 stream, then overrun: err only on the first extra bit.
    load_elems(2'd2, 2 * 16 * 64, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'($urandom), 2'($urandom), 1'b0, 1'b0);
      chk("overrun_err", err, i == 0);
      chk("overrun_elem_valid", elem_valid, 1'b0);
    end
    idle_cycle(1'b0);

    // Complete N=2 stream ending cleanly, then a fresh stream restarts at 0.
    load_elems(2'd0, 2 * 16 * 4, 1'b0, 1'b0);
    idle_cycle(1'b0);
    load_elems(2'd1, 3, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Back-to-back random index pairs, then the directed pair.
    for (int p = 0; p < 4; p++) begin
      ri = 4'($urandom);
      rw = 4'($urandom);
      idx_pair(ri, rw);
    end
    idx_pair(4'hB, 4'h6);
    idle_cycle(1'b0);
    chk("i_idx_hold", i_idx, 4'hB);
    chk("w_idx_hold", w_idx, 4'h6);

    // in_valid2 drops after two bits: pair discarded, previous pair held.
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    idle_cycle(1'b1);
    chk("i_idx_after_abort", i_idx, 4'hB);
    chk("w_idx_after_abort", w_idx, 4'h6);
    idle_cycle(1'b0);

    // Underrun: in_valid falls after 9 bits of the third element.
    load_elems(2'd1, 2, 1'b0, 1'b0);
    for (int b = 0; b < 9; b++) begin
      drive(1'b1, 1'b0, 1'($urandom), 2'($urandom), 1'b0, 1'b0);
      chk("underrun_bits_valid", elem_valid, 1'b0);
    end
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    load_elems(2'd1, 2, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // in_valid and in_valid2 together in IDLE: load wins, one err pulse.
    load_elems(2'd0, 2, 1'b0, 1'b1);
    idle_cycle(1'b0);

    // in_valid2 during LOAD: err pulses, the element still completes.
    for (int b = 0; b < 16; b++) begin
      drive(1'b1, b == 5, 1'b1, 2'd1, 1'b1, 1'b1);
      chk("v2_in_load_err", err, b == 5);
      chk("v2_in_load_idx_valid", idx_valid, 1'b0);
      chk("v2_in_load_elem_valid", elem_valid, b == 15);
    end
    chk("v2_in_load_data", elem_data, 16'hFFFF);
    idle_cycle(1'b0);

    // Asynchronous reset mid-load (element 3, bit 7).
    load_elems(2'd1, 3, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    in_valid = 0; in_valid2 = 0; matrix = 0; matrix_size = 0;
    i_mat_idx = 0; w_mat_idx = 0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle(1'b0);
    load_elems(2'd0, 8, 1'b1, 1'b0);
    idle_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
